// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative restoring divider.
package divider_iter_pkg;

  // Default operand width.
  localparam int XLEN_DEF = 64;

  // FSM state encoding.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Special results at the default width: quotient on divide-by-zero and
  // the dividend that overflows when divided by -1.
  localparam logic [XLEN_DEF-1:0] DIV_ZERO_Q       = '1;
  localparam logic [XLEN_DEF-1:0] DIV_OVF_DIVIDEND = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/divider_iter_step.sv
// One radix-2 restoring step: shift {rem, quo} left, trial-subtract divisor.
module div_restore_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // Partial remainder is always below the divisor, so it fits in XLEN bits;
  // only the shifted value needs the extra bit.
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Trial subtraction; the low XLEN bits of the difference are exact when it is non-negative.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    ge      = (shifted >= {1'b0, divisor_i});
    diff    = shifted[XLEN-1:0] - divisor_i;
    rem_o   = ge ? diff : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider with RISC-V M special-case handling.
module divider_iter
  import divider_iter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            block_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            sign_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            ready_o,
  output logic            valid_o
);

  // XLEN-sized forms of the special-result constants.
  localparam logic [XLEN-1:0] ZERO_Q  = '1;
  localparam logic [XLEN-1:0] OVF_DVD = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  remd_q, remd_d;

  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN-1:0]  dvd_abs, dvs_abs;
  logic             accept;

  assign ready_o     = (state_q != DIV_CALC);
  assign valid_o     = (state_q == DIV_DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = remd_q;
  assign accept      = req_valid_i & ready_o & ~block_i;

  // Magnitudes are only taken for signed requests with a negative operand.
  assign dvd_abs = (sign_i & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign dvs_abs = (sign_i & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Next-state, datapath load/step and result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    if (block_i) begin
      // Flush: drop any work, keep the last completed results.
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE, DIV_DONE: begin
          state_d = DIV_IDLE;
          if (accept) begin
            if (divisor_i == '0) begin
              state_d = DIV_DONE;
              quot_d  = ZERO_Q;
              remd_d  = dividend_i;
            end else if (sign_i && dividend_i == OVF_DVD && divisor_i == '1) begin
              state_d = DIV_DONE;
              quot_d  = dividend_i;
              remd_d  = '0;
            end else begin
              state_d = DIV_CALC;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = dvd_abs;
              dvs_d   = dvs_abs;
              negq_d  = sign_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
              negr_d  = sign_i & dividend_i[XLEN-1];
            end
          end
        end
        DIV_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DIV_DONE;
            quot_d  = negq_q ? -step_quo : step_quo;
            remd_d  = negr_q ? -step_rem : step_rem;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  // Control state and visible results, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
    end
  end

  // Working datapath registers; always reloaded on accept, so no reset needed.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: behavioural model plus directed vectors.
module tb_divider_iter;
  import divider_iter_pkg::*;

  localparam int XL = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          block_i = 1'b0;
  logic [XL-1:0] dividend_i = '0;
  logic [XL-1:0] divisor_i = '0;
  logic          sign_i = 1'b0;
  logic [XL-1:0] quotient_o, remainder_o;
  logic          ready_o, valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  divider_iter #(.XLEN(XL), .CNT_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .block_i     (block_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .sign_i      (sign_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .ready_o     (ready_o),
    .valid_o     (valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference result from the arithmetic definition of div/divu/rem/remu.
  function automatic void model(input logic [XL-1:0] a, input logic [XL-1:0] b, input bit s,
                                output logic [XL-1:0] q, output logic [XL-1:0] r,
                                output bit special);
    longint sa, sb;
    special = 1'b0;
    if (b == '0) begin
      q = DIV_ZERO_Q; r = a; special = 1'b1;
    end else if (s && a == DIV_OVF_DIVIDEND && b == '1) begin
      q = a; r = '0; special = 1'b1;
    end else if (s) begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Cycle-level expectations: edges left until the pending result, expected
  // valid in the current cycle, and the result values that must be visible.
  int            wait_left = 0;
  bit            vld_m = 1'b0;
  bit            started = 1'b0;
  logic [XL-1:0] out_q = '0, out_r = '0, pend_q = '0, pend_r = '0;

  // Model advance on each clock edge from the inputs presented before it.
  always @(posedge clk) begin
    logic [XL-1:0] q, r;
    bit sp, nv;
    if (rst) begin
      started = 1'b1; wait_left = 0; vld_m = 1'b0; out_q = '0; out_r = '0;
    end else if (block_i) begin
      wait_left = 0; vld_m = 1'b0;
    end else begin
      nv = 1'b0;
      if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) begin
          out_q = pend_q; out_r = pend_r; nv = 1'b1;
        end
      end else if (req_valid_i) begin
        model(dividend_i, divisor_i, sign_i, q, r, sp);
        if (sp) begin
          out_q = q; out_r = r; nv = 1'b1;
        end else begin
          pend_q = q; pend_r = r; wait_left = XL;
        end
      end
      vld_m = nv;
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (started) begin
      chk("valid_o", {63'd0, valid_o}, {63'd0, vld_m});
      chk("ready_o", {63'd0, ready_o}, {63'd0, (wait_left == 0)});
      chk("quotient_o", quotient_o, out_q);
      chk("remainder_o", remainder_o, out_r);
    end
  end

  task automatic issue(input logic [XL-1:0] a, input logic [XL-1:0] b, input bit s);
    req_valid_i = 1'b1; dividend_i = a; divisor_i = b; sign_i = s;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    // Scramble the operands to show they were captured.
    dividend_i = ~a; divisor_i = b ^ 64'h5; sign_i = ~s;
  endtask

  task automatic wait_valid(input int lat, input logic [XL-1:0] eq, input logic [XL-1:0] er,
                            input string nm);
    int n = 1;
    while (valid_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, XL'(n), XL'(lat));
    chk({nm, "_q"}, quotient_o, eq);
    chk({nm, "_r"}, remainder_o, er);
  endtask

  task automatic run(input logic [XL-1:0] a, input logic [XL-1:0] b, input bit s, input int lat,
                     input logic [XL-1:0] eq, input logic [XL-1:0] er, input string nm);
    @(posedge clk); #1;
    issue(a, b, s);
    wait_valid(lat, eq, er, nm);
  endtask

  initial begin
    logic [XL-1:0] q, r;
    bit sp;
    int pulses;

    // Pin the model to hand-computed values.
    model(64'd100, 64'd7, 1'b0, q, r, sp);
    chk("model_u_q", q, 64'd14); chk("model_u_r", r, 64'd2);
    model(-64'sd100, 64'd7, 1'b1, q, r, sp);
    chk("model_s1_q", q, 64'hFFFF_FFFF_FFFF_FFF2); chk("model_s1_r", r, 64'hFFFF_FFFF_FFFF_FFFE);
    model(64'd100, -64'sd7, 1'b1, q, r, sp);
    chk("model_s2_q", q, 64'hFFFF_FFFF_FFFF_FFF2); chk("model_s2_r", r, 64'd2);
    model(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, q, r, sp);
    chk("model_ovf_q", q, 64'h8000_0000_0000_0000); chk("model_ovf_r", r, 64'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_q", quotient_o, 64'd0);
    chk("rst_r", remainder_o, 64'd0);

    // Main function and special cases.
    run(64'd100, 64'd7, 1'b0, 65, 64'd14, 64'd2, "u100_7");
    run(-64'sd100, 64'd7, 1'b1, 65, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, "sn100_7");
    run(64'd100, -64'sd7, 1'b1, 65, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, "s100_n7");
    run(64'h1234, 64'd0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, "divzero");
    run(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1,
        64'h8000_0000_0000_0000, 64'd0, "sovf");
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "uones_1");

    // Back-to-back: accept in the DONE cycle.
    issue(64'd5, 64'd3, 1'b0);
    wait_valid(65, 64'd1, 64'd2, "b2b_5_3");

    // Flush at counter 30: no result, outputs retained.
    @(posedge clk); #1;
    issue(64'd1000, 64'd3, 1'b0);
    repeat (30) begin @(posedge clk); #1; end
    block_i = 1'b1;
    @(posedge clk); #1;
    block_i = 1'b0;
    chk("blk_ready", {63'd0, ready_o}, 64'd1);
    pulses = 0;
    repeat (100) begin
      if (valid_o === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    chk("blk_no_valid", XL'(pulses), 64'd0);
    chk("blk_q_kept", quotient_o, 64'd1);
    chk("blk_r_kept", remainder_o, 64'd2);

    // Flush and request together: flush wins.
    block_i = 1'b1;
    issue(64'd9, 64'd4, 1'b0);
    block_i = 1'b0;
    chk("blkreq_ready", {63'd0, ready_o}, 64'd1);
    chk("blkreq_valid", {63'd0, valid_o}, 64'd0);

    // Reset mid-calculation.
    issue(64'd77, 64'd5, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_ready", {63'd0, ready_o}, 64'd1);
    chk("mrst_valid", {63'd0, valid_o}, 64'd0);
    chk("mrst_q", quotient_o, 64'd0);
    chk("mrst_r", remainder_o, 64'd0);

    // Recovery after reset.
    run(-64'sd9, 64'd2, 1'b1, 65, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, "sn9_2");
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
